lc3_mem_responder: RTL



---
 rtl/lc3_mem_responder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: LC-3 SRAM-strobe responder with configurable read latency and byte-lane writes.
// Optional macro ADDR_CHECK_EN adds Mem_err with out-of-range address trapping.
`default_nettype none

module lc3_mem_responder #(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_CE,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic              Mem_UB,
  input  logic              Mem_LB,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [15:0]       Data_in,
  output logic [15:0]       Data_out,
  output logic              Rd_valid,
  output logic              Wr_ack,
  output logic              Busy
`ifdef ADDR_CHECK_EN
  ,
  output logic              Mem_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_HOLD, WR} state_t;

  state_t            state, state_nx;
  logic [2:0]        cnt, cnt_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [ADDR_W-1:0] load_addr;
  logic              load, commit, wr_en;
  logic              wr_dec, rd_dec, addr_chg;
  logic [15:0]       rd_word;
  logic [15:0]       mem [DEPTH];

  assign wr_dec   = !Mem_CE && !Mem_WE;
  assign rd_dec   = !Mem_CE && Mem_WE && !Mem_OE;
  assign addr_chg = (ADDR != addr_q);

`ifdef ADDR_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  function automatic logic oob(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= DEPTH_X;
  endfunction

  assign rd_word = oob(load_addr) ? 16'hDEAD : mem[load_addr[IDX_W-1:0]];
  assign wr_en   = commit && !oob(ADDR);
`else
  assign rd_word = mem[load_addr[IDX_W-1:0]];
  assign wr_en   = commit;
`endif

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    addr_nx   = addr_q;
    load      = 1'b0;
    load_addr = addr_q;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (wr_dec) begin
          state_nx = WR;
          commit   = 1'b1;
          addr_nx  = ADDR;
        end else if (rd_dec) begin
          addr_nx = ADDR;
          cnt_nx  = LAT_M1;
          if (RD_LAT == 1) begin
            state_nx  = RD_HOLD;
            load      = 1'b1;
            load_addr = ADDR;
          end else begin
            state_nx = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (wr_dec) begin
          state_nx = WR;
          commit   = 1'b1;
          addr_nx  = ADDR;
        end else if (rd_dec) begin
          if (cnt == 3'd1) begin
            state_nx = RD_HOLD;
            load     = 1'b1;
          end else begin
            cnt_nx = cnt - 3'd1;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      RD_HOLD: begin
        if (wr_dec) begin
          state_nx = WR;
          commit   = 1'b1;
          addr_nx  = ADDR;
        end else if (rd_dec) begin
          // A new address restarts the full latency for the new word
          if (addr_chg) begin
            addr_nx = ADDR;
            cnt_nx  = LAT_M1;
            if (RD_LAT == 1) begin
              load      = 1'b1;
              load_addr = ADDR;
            end else begin
              state_nx = RD_WAIT;
            end
          end
        end else begin
          state_nx = IDLE;
        end
      end
      WR: begin
        if (wr_dec) begin
          if (addr_chg) begin
            commit  = 1'b1;
            addr_nx = ADDR;
          end
        end else if (rd_dec) begin
          addr_nx = ADDR;
          cnt_nx  = LAT_M1;
          if (RD_LAT == 1) begin
            state_nx  = RD_HOLD;
            load      = 1'b1;
            load_addr = ADDR;
          end else begin
            state_nx = RD_WAIT;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      addr_q   <= '0;
      Data_out <= 16'h0000;
      Rd_valid <= 1'b0;
      Wr_ack   <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      addr_q   <= addr_nx;
      if (load) Data_out <= rd_word;
      Rd_valid <= (state_nx == RD_HOLD);
      Wr_ack   <= commit;
      Busy     <= (state_nx == RD_WAIT);
    end
  end

  // Array is not reset; a commit edge with Reset low is discarded
  always_ff @(posedge Clk) begin
    if (Reset && wr_en) begin
      if (!Mem_UB) mem[ADDR[IDX_W-1:0]][15:8] <= Data_in[15:8];
      if (!Mem_LB) mem[ADDR[IDX_W-1:0]][7:0]  <= Data_in[7:0];
    end
  end

`ifdef ADDR_CHECK_EN
  logic err_nx;

  always_comb begin
    err_nx = 1'b0;
    if (load) err_nx = oob(load_addr);
    else if (commit) err_nx = oob(ADDR);
    else if (state_nx == RD_HOLD || state_nx == WR) err_nx = Mem_err;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) Mem_err <= 1'b0;
    else        Mem_err <= err_nx;
  end
`endif

endmodule

`default_nettype wire
